// File: rtl/systolic_array_if.sv
// rtl/systolic_array_if.sv - bus bundle between the matrix engine and the systolic MAC array
// Purpose: groups the activation/psum buses, row enables and weight save strobe.
// Ports (signals):
//   in_a_bus   activations per row lane; weight word during preload
//   in_b_bus   top partial sums per column lane
//   enable     per-row compute enable
//   save       copy preloaded weights into active weights
//   out_a_bus  activations leaving the right column (debug)
//   out_b_bus  bottom-row sums, low lane bits per column
// Modports: master drives inputs and observes outputs; slave is the array.
interface systolic_array_if #(
  parameter int PE_ROW           = 16,
  parameter int PE_COL           = 16,
  parameter int INPUT_DATA_WIDTH = 8
);
  logic [PE_ROW*INPUT_DATA_WIDTH-1:0] in_a_bus;
  logic [PE_COL*INPUT_DATA_WIDTH-1:0] in_b_bus;
  logic [PE_ROW-1:0]                  enable;
  logic                               save;
  logic [PE_ROW*INPUT_DATA_WIDTH-1:0] out_a_bus;
  logic [PE_COL*INPUT_DATA_WIDTH-1:0] out_b_bus;

  modport master (
    output in_a_bus, in_b_bus, enable, save,
    input  out_a_bus, out_b_bus
  );

  modport slave (
    input  in_a_bus, in_b_bus, enable, save,
    output out_a_bus, out_b_bus
  );
endinterface

// File: rtl/systolic_array.sv
// rtl/systolic_array.sv - weight-stationary signed MAC array, compute core of the matrix engine
// Purpose: PE_ROW x PE_COL grid of MAC cells. Activations move right along rows,
//   partial sums move down columns, weights are shifted in from the top through
//   in_a_bus and made active with save.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous reset, active high (1 = reset)
//   bus   systolic_array_if.slave: in_a_bus, in_b_bus, enable, save -> out_a_bus, out_b_bus
module systolic_array #(
  parameter int PE_ROW            = 16,
  parameter int PE_COL            = 16,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int WEIGHT_DATA_WIDTH = 8,
  parameter int OUTPUT_DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  systolic_array_if.slave   bus
);

  localparam int IW = INPUT_DATA_WIDTH;
  localparam int WW = WEIGHT_DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;

  // Per-PE state
  logic signed [IW-1:0] r_a       [PE_ROW][PE_COL];
  logic signed [OW-1:0] r_psum    [PE_ROW][PE_COL];
  logic signed [WW-1:0] r_w_shift [PE_ROW][PE_COL];
  logic signed [WW-1:0] r_w_act   [PE_ROW][PE_COL];

  // Per-PE neighbour inputs and MAC result
  logic signed [IW-1:0] w_a_in    [PE_ROW][PE_COL];
  logic signed [OW-1:0] w_b_in    [PE_ROW][PE_COL];
  logic signed [WW-1:0] w_w_in    [PE_ROW][PE_COL];
  logic signed [OW-1:0] w_mac     [PE_ROW][PE_COL];

  for (genvar r = 0; r < PE_ROW; r++) begin : g_row
    for (genvar c = 0; c < PE_COL; c++) begin : g_col
      logic [OW-1:0] w_a_ext;
      logic [OW-1:0] w_w_ext;

      // Activation source: left edge takes the bus lane, others the left neighbour
      if (c == 0) begin : g_a_edge
        assign w_a_in[r][c] = bus.in_a_bus[r*IW +: IW];
      end else begin : g_a_chain
        assign w_a_in[r][c] = r_a[r][c-1];
      end

      // Partial-sum source: top edge sign-extends the bus lane, others the PE above
      if (r == 0) begin : g_b_edge
        assign w_b_in[r][c] = {{(OW-IW){bus.in_b_bus[c*IW+IW-1]}}, bus.in_b_bus[c*IW +: IW]};
        assign w_w_in[r][c] = bus.in_a_bus[c*WW +: WW];
      end else begin : g_b_chain
        assign w_b_in[r][c] = r_psum[r-1][c];
        assign w_w_in[r][c] = r_w_shift[r-1][c];
      end

      // Both operands sign-extended to the accumulator width; the low OW bits of
      // the OW-bit product equal the low bits of the full signed product.
      assign w_a_ext     = {{(OW-IW){w_a_in[r][c][IW-1]}}, w_a_in[r][c]};
      assign w_w_ext     = {{(OW-WW){r_w_act[r][c][WW-1]}}, r_w_act[r][c]};
      assign w_mac[r][c] = w_b_in[r][c] + w_a_ext * w_w_ext;

      if (c == PE_COL-1) begin : g_out_a
        assign bus.out_a_bus[r*IW +: IW] = r_a[r][c];
      end
      if (r == PE_ROW-1) begin : g_out_b
        assign bus.out_b_bus[c*IW +: IW] = r_psum[r][c][IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int r = 0; r < PE_ROW; r++) begin
        for (int c = 0; c < PE_COL; c++) begin
          r_a[r][c]       <= '0;
          r_psum[r][c]    <= '0;
          r_w_shift[r][c] <= '0;
          r_w_act[r][c]   <= '0;
        end
      end
    end else begin
      for (int r = 0; r < PE_ROW; r++) begin
        for (int c = 0; c < PE_COL; c++) begin
          // Weight chain runs every clock so preload can overlap compute
          r_w_shift[r][c] <= w_w_in[r][c];
          // Active weights take the pre-edge chain contents; compute this edge
          // still sees the old r_w_act
          if (bus.save) begin
            r_w_act[r][c] <= r_w_shift[r][c];
          end
          if (bus.enable[r]) begin
            r_a[r][c]    <= w_a_in[r][c];
            r_psum[r][c] <= w_mac[r][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// tb/tb_systolic_array.sv - randomized bench for systolic_array against a dot-product reference
module tb_systolic_array;
  localparam int R    = 16;
  localparam int C    = 16;
  localparam int MAXE = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  systolic_array_if #(.PE_ROW(R), .PE_COL(C), .INPUT_DATA_WIDTH(8)) bus ();

  systolic_array #(
    .PE_ROW(R), .PE_COL(C), .INPUT_DATA_WIDTH(8),
    .WEIGHT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(32)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference history: bus values per edge since time 0, weight set in force per edge
  logic [127:0]       a_hist   [MAXE];
  logic [127:0]       b_hist   [MAXE];
  int                 wid_hist [MAXE];
  logic signed [7:0]  wsets    [32][R][C];
  int                 n_sets;
  int                 cur_wid;
  int                 e;
  int                 reset_mark;
  int                 last_dis;
  // Accepted activations per row: the row is a 16-deep delay line advancing on enable
  logic [7:0]         acc      [R][MAXE];
  int                 acc_n    [R];
  logic [127:0]       wrows    [R];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] splat(input logic [7:0] v);
    logic [127:0] x;
    for (int i = 0; i < 16; i++) x[i*8 +: 8] = v;
    return x;
  endfunction

  task automatic model_reset();
    reset_mark = e;
    last_dis   = e - 1;
    cur_wid    = 0;
    for (int r = 0; r < R; r++) acc_n[r] = 0;
  endtask

  task automatic check_outputs();
    logic [127:0] exp_a;
    for (int r = 0; r < R; r++)
      exp_a[r*8 +: 8] = (acc_n[r] >= C) ? acc[r][acc_n[r]-C] : 8'h00;
    check_eq("out_a", bus.out_a_bus, exp_a);
    // Column c after edge e holds b(e-15) + sum_r a_r(e-15+r-c) * W_active(e-15+r)[r][c]
    for (int c = 0; c < C; c++) begin
      if (e - (R-1) - c > last_dis) begin
        int s;
        s = $signed(b_hist[e-(R-1)][c*8 +: 8]);
        for (int r = 0; r < R; r++) begin
          int ai;
          int wi;
          ai = $signed(a_hist[e-(R-1)+r-c][r*8 +: 8]);
          wi = wsets[wid_hist[e-(R-1)+r]][r][c];
          s += ai * wi;
        end
        check_eq($sformatf("out_b[%0d]@%0d", c, e), {120'd0, bus.out_b_bus[c*8 +: 8]}, {120'd0, s[7:0]});
      end
    end
  endtask

  task automatic step(input logic [127:0] a, input logic [127:0] b, input logic [15:0] en, input logic sv);
    if (e >= MAXE) begin
      $display("FAIL history_overflow got=%0d exp<%0d", e, MAXE);
      $fatal(1, "history overflow");
    end
    bus.in_a_bus = a;
    bus.in_b_bus = b;
    bus.enable   = en;
    bus.save     = sv;
    @(posedge clk);
    a_hist[e]   = a;
    b_hist[e]   = b;
    wid_hist[e] = cur_wid;
    if (en != 16'hFFFF) last_dis = e;
    for (int r = 0; r < R; r++) begin
      if (en[r]) begin
        acc[r][acc_n[r]] = a[r*8 +: 8];
        acc_n[r]++;
      end
    end
    if (sv) begin
      // Row k takes the word presented k edges before the last pre-save shift
      n_sets++;
      for (int k = 0; k < R; k++) begin
        for (int c = 0; c < C; c++) begin
          int j;
          j = e - 1 - k;
          if (j >= reset_mark) wsets[n_sets][k][c] = a_hist[j][c*8 +: 8];
          else                 wsets[n_sets][k][c] = 8'sd0;
        end
      end
      cur_wid = n_sets;
    end
    #1;
    check_outputs();
    e++;
  endtask

  task automatic reset_hold(input int n);
    rstn = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.in_a_bus = rnd128();
      bus.in_b_bus = rnd128();
      bus.enable   = 16'($urandom);
      bus.save     = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("rst_out_a", bus.out_a_bus, 128'd0);
      check_eq("rst_out_b", bus.out_b_bus, 128'd0);
    end
    rstn = 1'b0;
    model_reset();
  endtask

  task automatic preload(input logic [15:0] en);
    for (int k = R-1; k >= 0; k--) step(wrows[k], 128'd0, en, 1'b0);
    step(rnd128(), 128'd0, en, 1'b1);
  endtask

  task automatic run_stream(input int nvec);
    logic [7:0]   x [32][R];
    logic [127:0] a;
    for (int t = 0; t < nvec; t++)
      for (int r = 0; r < R; r++) x[t][r] = 8'($urandom);
    for (int k = 0; k < nvec + R + C; k++) begin
      for (int r = 0; r < R; r++)
        a[r*8 +: 8] = (k - r >= 0 && k - r < nvec) ? x[k-r][r] : 8'h00;
      step(a, 128'd0, 16'hFFFF, 1'b0);
    end
  endtask

  task automatic run_const(input logic [127:0] a, input logic [127:0] b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 16'hFFFF, 1'b0);
  endtask

  task automatic run_rand(input int n, input logic [15:0] en);
    for (int i = 0; i < n; i++) step(rnd128(), rnd128(), en, 1'b0);
  endtask

  initial begin
    bus.in_a_bus = '0;
    bus.in_b_bus = '0;
    bus.enable   = '0;
    bus.save     = 1'b0;
    e      = 0;
    n_sets = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wsets[0][r][c] = 8'sd0;

    // Reset with random inputs, then idle with enables low
    reset_hold(4);
    for (int i = 0; i < 5; i++) begin
      step(rnd128(), rnd128(), 16'h0000, 1'($urandom));
      check_eq("idle_out_b", bus.out_b_bus, 128'd0);
    end

    // Identity weights: bottom row replays skewed activation columns
    for (int k = 0; k < R; k++) begin
      wrows[k] = '0;
      wrows[k][k*8 +: 8] = 8'd1;
    end
    preload(16'h0000);
    run_stream(20);

    // Constant patterns, including negative weights and wrap of the truncated sum
    for (int k = 0; k < R; k++) wrows[k] = splat(8'd2);
    preload(16'h0000);
    run_const(splat(8'd3), 128'd0, 40);
    for (int k = 0; k < R; k++) wrows[k] = splat(8'hFF);
    preload(16'h0000);
    run_const(splat(8'd5), splat(8'd7), 40);
    for (int k = 0; k < R; k++) wrows[k] = splat(8'd127);
    preload(16'h0000);
    run_const(splat(8'd127), 128'd0, 40);

    // Random weights, random sums, row 5 stalled for three edges mid-stream
    for (int k = 0; k < R; k++) wrows[k] = rnd128();
    preload(16'h0000);
    run_rand(30, 16'hFFFF);
    run_rand(3, 16'hFFDF);
    run_rand(40, 16'hFFFF);

    // New weights shifted during compute, save on an enabled edge
    for (int k = 0; k < R; k++) wrows[k] = rnd128();
    preload(16'hFFFF);
    run_rand(40, 16'hFFFF);

    // Reset mid-stream clears weights too: output then equals the top sums
    reset_hold(2);
    run_rand(40, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
